// File: rtl/ir_pkg.sv
// Shared loader/decoder definitions: FSM state encoding and default IR widths.
// Combinational-free package; no latency or backpressure of its own.
package ir_pkg;

  localparam int IR_DATA_WIDTH = 8;
  localparam int IR_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_INIT_RD    = 3'd1,
    S_INIT_WAIT  = 3'd2,
    S_INIT_WR    = 3'd3,
    S_FETCH_RD   = 3'd4,
    S_FETCH_WAIT = 3'd5,
    S_ISSUE      = 3'd6
  } state_t;

endpackage

// File: rtl/ir_addr_counter.sv
// Word counter with clear/increment/last-compare and a wrapping base+count adder.
// Count updates one cycle after inc; addr and last are pure decode of the count.
module ir_addr_counter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] limit,
  output logic [ADDR_WIDTH-1:0] cnt,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign addr = base + cnt;
  assign last = (cnt == limit);

endmodule

// File: rtl/ir_loader.sv
// Instruction loader: bulk-copies cache words into the IR regfile or fetches opcode+operands.
// 3 cycles/word on a zero-wait cache; waits on cache_rvalid and holds ISSUE until ir_ready.
module ir_loader
  import ir_pkg::*;
#(
  parameter int DATA_WIDTH = IR_DATA_WIDTH,
  parameter int ADDR_WIDTH = IR_ADDR_WIDTH,
  parameter int NUM_PARAMS = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             init,
  input  logic [ADDR_WIDTH-1:0]            init_src,
  input  logic [ADDR_WIDTH-1:0]            init_dst,
  input  logic [ADDR_WIDTH-1:0]            init_len,
  input  logic                             fetch,
  input  logic [ADDR_WIDTH-1:0]            pc,
  output logic                             cache_ren,
  output logic [ADDR_WIDTH-1:0]            cache_addr,
  input  logic [DATA_WIDTH-1:0]            cache_rdata,
  input  logic                             cache_rvalid,
  output logic                             irf_wen,
  output logic [ADDR_WIDTH-1:0]            irf_waddr,
  output logic [DATA_WIDTH-1:0]            irf_wdata,
  output logic                             ir_valid,
  input  logic                             ir_ready,
  output logic [DATA_WIDTH-1:0]            ir_op,
  output logic [NUM_PARAMS*DATA_WIDTH-1:0] ir_params,
  output logic                             busy,
  output logic                             done
);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   rd_base, wr_base, limit;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_addr, cnt_base;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    cnt_clr, cnt_inc, cnt_last;

  // One adder serves both address streams: the write base is only selected in INIT_WR.
  assign cnt_base = (state == S_INIT_WR) ? wr_base : rd_base;

  ir_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .base  (cnt_base),
    .limit (limit),
    .cnt   (cnt),
    .addr  (cnt_addr),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (init) begin
          if (init_len != '0) state_nxt = S_INIT_RD;
        end else if (fetch) begin
          state_nxt = S_FETCH_RD;
        end
      end
      S_INIT_RD:   state_nxt = S_INIT_WAIT;
      S_INIT_WAIT: if (cache_rvalid) state_nxt = S_INIT_WR;
      S_INIT_WR: begin
        if (cnt_last) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_inc   = 1'b1;
          state_nxt = S_INIT_RD;
        end
      end
      S_FETCH_RD:  state_nxt = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        if (cache_rvalid) begin
          if (cnt_last) begin
            state_nxt = S_ISSUE;
          end else begin
            cnt_inc   = 1'b1;
            state_nxt = S_FETCH_RD;
          end
        end
      end
      S_ISSUE:     if (ir_ready) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cache_ren  = 1'b0;
    cache_addr = '0;
    irf_wen    = 1'b0;
    irf_waddr  = '0;
    irf_wdata  = '0;
    ir_valid   = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_INIT_RD, S_FETCH_RD: begin
        cache_ren  = 1'b1;
        cache_addr = cnt_addr;
      end
      S_INIT_WR: begin
        irf_wen   = 1'b1;
        irf_waddr = cnt_addr;
        irf_wdata = wdata;
      end
      S_ISSUE:  ir_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_base   <= '0;
      wr_base   <= '0;
      limit     <= '0;
      wdata     <= '0;
      ir_op     <= '0;
      ir_params <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (init) begin
            rd_base <= init_src;
            wr_base <= init_dst;
            limit   <= init_len - 1'b1;
            done    <= (init_len == '0);
          end else if (fetch) begin
            rd_base <= pc;
            limit   <= ADDR_WIDTH'(NUM_PARAMS);
          end
        end
        S_INIT_WAIT: if (cache_rvalid) wdata <= cache_rdata;
        S_INIT_WR:   done <= cnt_last;
        S_FETCH_WAIT: begin
          if (cache_rvalid) begin
            if (cnt == '0) ir_op <= cache_rdata;
            for (int k = 0; k < NUM_PARAMS; k++) begin
              if (cnt == ADDR_WIDTH'(k + 1)) ir_params[k*DATA_WIDTH +: DATA_WIDTH] <= cache_rdata;
            end
          end
        end
        S_ISSUE:     done <= ir_ready;
        default:     ;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_loader.sv
// Bench for ir_loader: cache model, scoreboard of regfile writes / issues / done pulses.
module tb_ir_loader;

  localparam int K_WR   = 0;
  localparam int K_ISS  = 1;
  localparam int K_DONE = 2;

  logic        clk, rst;
  logic        init, fetch, cache_ren, cache_rvalid, irf_wen, ir_valid, ir_ready, busy, done;
  logic [7:0]  init_src, init_dst, init_len, pc, cache_addr, cache_rdata;
  logic [7:0]  irf_waddr, irf_wdata, ir_op;
  logic [23:0] ir_params;

  ir_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_PARAMS(3)) dut (
    .clk(clk), .rst(rst), .init(init), .init_src(init_src), .init_dst(init_dst),
    .init_len(init_len), .fetch(fetch), .pc(pc), .cache_ren(cache_ren),
    .cache_addr(cache_addr), .cache_rdata(cache_rdata), .cache_rvalid(cache_rvalid),
    .irf_wen(irf_wen), .irf_waddr(irf_waddr), .irf_wdata(irf_wdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_op(ir_op), .ir_params(ir_params),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [23:0] params;
  } exp_t;

  exp_t       exq[$];
  int         passed = 0;
  int         total  = 0;
  int         lat    = 1;
  int         ren_count = 0;
  logic [7:0] mem [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input int kind, input logic [7:0] a, input logic [7:0] d, input logic [23:0] p);
    exp_t e;
    e.kind = kind; e.addr = a; e.data = d; e.params = p;
    exq.push_back(e);
  endtask

  task automatic score(input int kind, input logic [7:0] a, input logic [7:0] d, input logic [23:0] p);
    exp_t e;
    total++;
    if (exq.size() == 0) begin
      $display("FAIL scoreboard: unexpected event kind %0d addr %0h data %0h params %0h", kind, a, d, p);
      return;
    end
    e = exq.pop_front();
    if (e.kind == kind && e.addr == a && e.data == d && e.params == p) passed++;
    else $display("FAIL scoreboard: got kind %0d addr %0h data %0h params %0h, expected kind %0d addr %0h data %0h params %0h",
                  kind, a, d, p, e.kind, e.addr, e.data, e.params);
  endtask

  // Cache responder: rvalid arrives `lat` cycles after the ren cycle, regardless of reset.
  initial begin
    logic [7:0] ra;
    cache_rvalid = 1'b0;
    cache_rdata  = 8'h00;
    forever begin
      @(negedge clk);
      if (cache_ren) begin
        ra = cache_addr;
        ren_count++;
        repeat (lat) @(posedge clk);
        #1 cache_rvalid = 1'b1;
        cache_rdata = mem[ra];
        @(posedge clk);
        #1 cache_rvalid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (irf_wen)              score(K_WR, irf_waddr, irf_wdata, 24'h0);
        if (ir_valid && ir_ready) score(K_ISS, 8'h00, ir_op, ir_params);
        if (done)                 score(K_DONE, 8'h00, 8'h00, 24'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

  task automatic start_init(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    @(posedge clk); #1;
    init = 1'b1; init_src = s; init_dst = d; init_len = l;
    @(posedge clk); #1;
    init = 1'b0;
  endtask

  task automatic start_fetch(input logic [7:0] p);
    @(posedge clk); #1;
    fetch = 1'b1; pc = p;
    @(posedge clk); #1;
    fetch = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 300);
    chk({name, " reaches idle"}, {31'b0, busy}, 32'h0);
  endtask

  initial begin
    int cyc;
    int r0;
    rst = 1'b1; init = 1'b0; fetch = 1'b0; ir_ready = 1'b0;
    init_src = 8'h00; init_dst = 8'h00; init_len = 8'h00; pc = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA0; mem[8'h11] = 8'hA1; mem[8'h12] = 8'hA2; mem[8'h13] = 8'hA3;
    mem[8'hFE] = 8'hB0; mem[8'hFF] = 8'hB1; mem[8'h00] = 8'hB2;
    mem[8'h20] = 8'h11; mem[8'h21] = 8'h22; mem[8'h22] = 8'h33; mem[8'h23] = 8'h44;
    mem[8'h30] = 8'h05; mem[8'h31] = 8'h06; mem[8'h32] = 8'h07; mem[8'h33] = 8'h08;
    mem[8'h40] = 8'hC0; mem[8'h41] = 8'hC1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset cache_ren", {31'b0, cache_ren}, 0);
    chk("reset irf_wen", {31'b0, irf_wen}, 0);
    chk("reset ir_valid", {31'b0, ir_valid}, 0);
    chk("reset busy", {31'b0, busy}, 0);
    chk("reset done", {31'b0, done}, 0);
    chk("reset ir_params", {8'b0, ir_params}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Straight 4-word copy on a zero-wait cache
    for (int i = 0; i < 4; i++) push(K_WR, 8'(i), 8'hA0 + 8'(i), 24'h0);
    push(K_DONE, 8'h00, 8'h00, 24'h0);
    start_init(8'h10, 8'h00, 8'd4);
    cyc = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done) begin cyc = n - 1; break; end
    end
    chk("init4 done cycle", cyc, 12);
    chk("init4 busy after done", {31'b0, busy}, 0);

    // Source and destination both wrap through 0xFF
    push(K_WR, 8'hFF, 8'hB0, 24'h0);
    push(K_WR, 8'h00, 8'hB1, 24'h0);
    push(K_WR, 8'h01, 8'hB2, 24'h0);
    push(K_DONE, 8'h00, 8'h00, 24'h0);
    start_init(8'hFE, 8'hFF, 8'd3);
    wait_idle("init wrap");

    // Fetch with a 3-cycle cache and a stalled decoder
    lat = 3;
    push(K_ISS, 8'h00, 8'h11, 24'h443322);
    push(K_DONE, 8'h00, 8'h00, 24'h0);
    start_fetch(8'h20);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ir_valid) break;
    end
    chk("fetch issue reached", {31'b0, ir_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      chk("issue held valid", {31'b0, ir_valid}, 1);
      chk("issue held op", {24'b0, ir_op}, 32'h11);
      @(negedge clk);
    end
    @(posedge clk); #1 ir_ready = 1'b1;
    @(posedge clk); #1 ir_ready = 1'b0;
    @(negedge clk);
    chk("fetch done after ready", {31'b0, done}, 1);
    chk("fetch valid dropped", {31'b0, ir_valid}, 0);
    chk("fetch op held", {24'b0, ir_op}, 32'h11);
    chk("fetch params held", {8'b0, ir_params}, 32'h443322);
    lat = 1;

    // init+fetch together: init wins; a fetch while busy is dropped
    push(K_WR, 8'h80, 8'hA0, 24'h0);
    push(K_WR, 8'h81, 8'hA1, 24'h0);
    push(K_DONE, 8'h00, 8'h00, 24'h0);
    @(posedge clk); #1;
    init = 1'b1; fetch = 1'b1; init_src = 8'h10; init_dst = 8'h80; init_len = 8'd2; pc = 8'h30;
    @(posedge clk); #1 init = 1'b0; fetch = 1'b0;
    @(posedge clk); #1 fetch = 1'b1;
    @(posedge clk); #1 fetch = 1'b0;
    wait_idle("init priority");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dropped fetch no valid", {31'b0, ir_valid}, 0);
      chk("dropped fetch idle", {31'b0, busy}, 0);
    end

    // Zero-wait fetch reaches ISSUE after 2*(NUM_PARAMS+1) cycles
    push(K_ISS, 8'h00, 8'h05, 24'h080706);
    push(K_DONE, 8'h00, 8'h00, 24'h0);
    start_fetch(8'h30);
    cyc = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (ir_valid) begin cyc = n - 1; break; end
    end
    chk("fetch zero-wait latency", cyc, 8);
    @(posedge clk); #1 ir_ready = 1'b1;
    @(posedge clk); #1 ir_ready = 1'b0;
    wait_idle("fetch zero-wait");

    // Zero-length init is a no-op apart from done
    push(K_DONE, 8'h00, 8'h00, 24'h0);
    r0 = ren_count;
    start_init(8'h50, 8'h60, 8'd0);
    @(negedge clk);
    chk("len0 done", {31'b0, done}, 1);
    chk("len0 busy", {31'b0, busy}, 0);
    chk("len0 cache_ren", {31'b0, cache_ren}, 0);
    @(negedge clk);
    chk("len0 done single", {31'b0, done}, 0);
    chk("len0 no reads", ren_count, r0);

    // Reset during INIT_WAIT; the late rvalid must not cause a write
    lat = 3;
    start_init(8'h40, 8'h50, 8'd2);
    @(posedge clk); #1;
    chk("pre-reset busy", {31'b0, busy}, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post-reset no write", {31'b0, irf_wen}, 0);
      chk("post-reset idle", {31'b0, busy}, 0);
      chk("post-reset no done", {31'b0, done}, 0);
    end
    chk("post-reset cache_addr", {24'b0, cache_addr}, 0);
    chk("post-reset irf_waddr", {24'b0, irf_waddr}, 0);
    chk("post-reset irf_wdata", {24'b0, irf_wdata}, 0);
    chk("post-reset ir_op", {24'b0, ir_op}, 0);
    chk("post-reset ir_params", {8'b0, ir_params}, 0);
    chk("post-reset ir_valid", {31'b0, ir_valid}, 0);
    lat = 1;

    chk("scoreboard drained", exq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ir_loader.md
# ir_loader

Parametrised instruction loader between the instruction cache and the decoder. It has two modes. Init mode bulk-copies a block of cache words into the IR register file. Fetch mode reads one opcode plus `NUM_PARAMS` operand words starting at a program counter and presents them to the decoder over a valid/ready handshake. It generalises the fixed three-parameter, fixed-count loader with configurable widths, a configurable operand count, a source/destination/length bulk copy, and a cache read handshake with variable latency.

## Interface
Parameters:
- `DATA_WIDTH`, 8: cache word, IR regfile entry and operand width.
- `ADDR_WIDTH`, 8: cache and IR regfile address width; all addresses wrap modulo 2^ADDR_WIDTH.
- `NUM_PARAMS`, 3: operand words fetched after each opcode; minimum 1.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `init` in 1: start a bulk load; sampled only in IDLE.
- `init_src` in ADDR_WIDTH: first cache address to copy; sampled with `init`.
- `init_dst` in ADDR_WIDTH: first IR regfile address to write; sampled with `init`.
- `init_len` in ADDR_WIDTH: number of words to copy; 0 is a no-op.
- `fetch` in 1: start an instruction fetch; sampled only in IDLE.
- `pc` in ADDR_WIDTH: opcode address; sampled with `fetch`.
- `cache_ren` out 1: one-cycle read request.
- `cache_addr` out ADDR_WIDTH: read address, valid while `cache_ren` is high.
- `cache_rdata` in DATA_WIDTH: read data, qualified by `cache_rvalid`.
- `cache_rvalid` in 1: read data valid, returned one or more cycles after `cache_ren`.
- `irf_wen` out 1: IR regfile write strobe.
- `irf_waddr` out ADDR_WIDTH: IR regfile write address.
- `irf_wdata` out DATA_WIDTH: IR regfile write data.
- `ir_valid` out 1: fetched instruction available to the decoder.
- `ir_ready` in 1: decoder accepts the instruction.
- `ir_op` out DATA_WIDTH: opcode word.
- `ir_params` out NUM_PARAMS*DATA_WIDTH: operand k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when an init or fetch completes.

## Operation
- States: IDLE, INIT_RD, INIT_WAIT, INIT_WR, FETCH_RD, FETCH_WAIT, ISSUE.
- IDLE:
  - `init` has priority over `fetch` when both are high.
  - `init` with `init_len`=0 stays in IDLE and pulses `done` next cycle.
  - `init` with nonzero length latches src, dst and len, clears the word counter and goes to INIT_RD.
  - `fetch` latches `pc`, clears the counter and goes to FETCH_RD.
- INIT_RD: `cache_ren`=1, `cache_addr`=src+cnt; go to INIT_WAIT.
- INIT_WAIT:
  - Hold until `cache_rvalid`.
  - On `cache_rvalid`, capture `cache_rdata` into the write data register and go to INIT_WR.
- INIT_WR:
  - Drive `irf_wen`=1, `irf_waddr`=dst+cnt, `irf_wdata`=captured word.
  - If cnt==len-1, go to IDLE and pulse `done`.
  - Otherwise cnt++ and go to INIT_RD.
- FETCH_RD: `cache_ren`=1, `cache_addr`=pc+cnt; go to FETCH_WAIT.
- FETCH_WAIT:
  - On `cache_rvalid`, store the word: cnt 0 goes to `ir_op`, cnt k goes to operand k-1.
  - If cnt==NUM_PARAMS, go to ISSUE; otherwise cnt++ and go to FETCH_RD.
- ISSUE:
  - `ir_valid`=1 and `ir_op`/`ir_params` are held stable.
  - On `ir_ready`, go to IDLE and pulse `done`.
- `init`/`fetch` asserted while `busy` are ignored; they are not queued.
- `cache_rvalid` outside the WAIT states is ignored.
- Address adds are ADDR_WIDTH-bit and wrap. The counter is ADDR_WIDTH bits wide, sufficient for len ≤ 2^ADDR_WIDTH−1.
- `rst` mid-operation: return immediately to IDLE and abandon any outstanding cache read. A late `cache_rvalid` is ignored.

## Timing
- Reset values: state IDLE; `cache_ren`, `irf_wen`, `ir_valid`, `busy`, `done` = 0; `cache_addr`, `irf_waddr`, `irf_wdata`, `ir_op`, `ir_params` = 0.
- All outputs come from registers or decode of the state register; there are no combinational paths from inputs to outputs.
- Zero-wait cache (rvalid the cycle after ren):
  - Init costs 3 cycles per word; N words finish in 3N cycles after the `init` edge.
  - Fetch reaches ISSUE 2*(NUM_PARAMS+1) cycles after the `fetch` edge.
- `done` is high for exactly the one cycle after the last INIT_WR, or after ISSUE with `ir_ready`.
- `ir_op`/`ir_params` hold their values after ISSUE until the next fetch overwrites them.

## Structure
- Shared package `ir_pkg`: state encoding enum and IR address/data width defaults, shared with the decoder.
- One sub-module, `ir_addr_counter`: word counter with clear, increment and last-compare, plus base+offset wrap adder. It is instanced once and used by both modes.

## Test plan
- Reset mid-INIT_WAIT with `cache_rvalid` pulsed 2 cycles later -> no `irf_wen`, state IDLE, `busy`=0, all outputs 0.
- `init` src=0x10, dst=0x00, len=4, zero-wait cache returning 0xA0..0xA3 -> 4 writes to addresses 0..3 with data A0..A3, `done` at cycle 12.
- `init` src=0xFE, dst=0xFF, len=3 -> reads FE,FF,00; writes FF,00,01 (wrap).
- `fetch` pc=0x20, cache latency 3 cycles, data 0x11,0x22,0x33,0x44 -> `ir_op`=0x11, `ir_params`=0x443322; `ir_valid` held for 5 cycles while `ir_ready`=0; `done` the cycle after `ir_ready`.
- `init` and `fetch` asserted together in IDLE -> init runs and the fetch is dropped. `fetch` pulsed while `busy` -> ignored.
- `init_len`=0 -> no `cache_ren`; `done` pulse one cycle later.
